// File: rtl/ex_mul_acc_pkg.sv
// Shared constants for the EX-stage multiply / multiply-accumulate slice.
// Holds the ALU opcode encodings, bus widths, reset/write-enable levels and
// the accumulate FSM state encoding used by ex_mul_acc.
package ex_mul_acc_pkg;

  localparam int unsigned AluOpW = 8;
  localparam int unsigned RegW   = 32;

  localparam logic [RegW-1:0] ZeroWord    = '0;
  localparam logic            RstEnable   = 1'b1;
  localparam logic            WriteEnable = 1'b1;

  localparam logic [AluOpW-1:0] ExeMultOp  = 8'b0001_1000;
  localparam logic [AluOpW-1:0] ExeMultuOp = 8'b0001_1001;
  localparam logic [AluOpW-1:0] ExeMulOp   = 8'b1010_1001;
  localparam logic [AluOpW-1:0] ExeMaddOp  = 8'b1010_0110;
  localparam logic [AluOpW-1:0] ExeMadduOp = 8'b1010_1000;
  localparam logic [AluOpW-1:0] ExeMsubOp  = 8'b1010_1010;
  localparam logic [AluOpW-1:0] ExeMsubuOp = 8'b1010_1011;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StAcc  = 1'b1
  } acc_state_e;

  // Ops whose operands are interpreted as two's-complement.
  function automatic logic is_signed_op(input logic [AluOpW-1:0] op);
    return (op == ExeMultOp) || (op == ExeMulOp) || (op == ExeMaddOp) || (op == ExeMsubOp);
  endfunction

  function automatic logic is_acc_op(input logic [AluOpW-1:0] op);
    return (op == ExeMaddOp) || (op == ExeMadduOp) || (op == ExeMsubOp) || (op == ExeMsubuOp);
  endfunction

  function automatic logic is_sub_op(input logic [AluOpW-1:0] op);
    return (op == ExeMsubOp) || (op == ExeMsubuOp);
  endfunction

endpackage

// File: rtl/ex_mul_acc_mul32x32u.sv
// mul32x32u: purely combinational 32x32 -> 64 unsigned multiplier.
// Ports:
//   a_i, b_i : 32-bit unsigned operands
//   p_o      : 64-bit unsigned product
module mul32x32u (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  assign p_o = {32'd0, a_i} * {32'd0, b_i};

endmodule

// File: rtl/ex_mul_acc.sv
// ex_mul_acc: EX-stage multiplier with optional two-cycle multiply-accumulate.
// MULT/MULTU write HI/LO and MUL writes a GPR result in the same cycle. With
// EX_MUL_ACC_MADD_EN defined, MADD/MADDU/MSUB/MSUBU run a two-state FSM: the
// first cycle registers the (possibly negated) product and stalls, the second
// adds it to the forwarded HI/LO and writes back. Without the macro those ops
// produce zero outputs and no stall.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   aluop_i           : decoded operation
//   reg1_i, reg2_i    : forwarded operands
//   hi_i, lo_i        : forwarded HI/LO
//   flush_i           : abandon any accumulate in progress
//   stallreq_from_ex  : stall request to pipeline control
//   mul_wdata_o       : GPR result for MUL
//   hi_o, lo_o        : new HI/LO value
//   whilo_o           : HI/LO write enable
module ex_mul_acc
  import ex_mul_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [AluOpW-1:0] aluop_i,
  input  logic [RegW-1:0]   reg1_i,
  input  logic [RegW-1:0]   reg2_i,
  input  logic [RegW-1:0]   hi_i,
  input  logic [RegW-1:0]   lo_i,
  input  logic              flush_i,
  output logic              stallreq_from_ex,
  output logic [RegW-1:0]   mul_wdata_o,
  output logic [RegW-1:0]   hi_o,
  output logic [RegW-1:0]   lo_o,
  output logic              whilo_o
);

  logic            signed_op;
  logic [RegW-1:0] op1_mag;
  logic [RegW-1:0] op2_mag;
  logic [63:0]     prod_u;
  logic [63:0]     product;

  // Sign-magnitude multiply: the shared unsigned core sees magnitudes only.
  always_comb begin
    signed_op = is_signed_op(aluop_i);
    op1_mag   = (signed_op && reg1_i[RegW-1]) ? (~reg1_i + 32'd1) : reg1_i;
    op2_mag   = (signed_op && reg2_i[RegW-1]) ? (~reg2_i + 32'd1) : reg2_i;
  end

  mul32x32u u_mul (
    .a_i (op1_mag),
    .b_i (op2_mag),
    .p_o (prod_u)
  );

  always_comb begin
    if (signed_op && (reg1_i[RegW-1] ^ reg2_i[RegW-1])) begin
      product = ~prod_u + 64'd1;
    end else begin
      product = prod_u;
    end
  end

`ifdef EX_MUL_ACC_MADD_EN
  acc_state_e  state_q, state_d;
  logic [63:0] hilo_temp_q, hilo_temp_d;
  logic [63:0] acc_sum;

  assign acc_sum = hilo_temp_q + {hi_i, lo_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q     <= StIdle;
      hilo_temp_q <= '0;
    end else begin
      state_q     <= state_d;
      hilo_temp_q <= hilo_temp_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    hilo_temp_d      = hilo_temp_q;
    stallreq_from_ex = 1'b0;
    whilo_o          = 1'b0;
    mul_wdata_o      = ZeroWord;
    hi_o             = ZeroWord;
    lo_o             = ZeroWord;

    if (is_acc_op(aluop_i)) begin
      if (flush_i) begin
        state_d = StIdle;
      end else if (state_q == StIdle) begin
        hilo_temp_d      = is_sub_op(aluop_i) ? (~product + 64'd1) : product;
        stallreq_from_ex = 1'b1;
        state_d          = StAcc;
      end else begin
        {hi_o, lo_o} = acc_sum;
        whilo_o      = WriteEnable;
        state_d      = StIdle;
      end
    end else begin
      // Any non-accumulate op (or a flush) abandons a pending accumulate.
      state_d = StIdle;
      if (aluop_i == ExeMultOp || aluop_i == ExeMultuOp) begin
        {hi_o, lo_o} = product;
        whilo_o      = WriteEnable;
      end else if (aluop_i == ExeMulOp) begin
        mul_wdata_o = product[RegW-1:0];
      end
    end

    // Reset blanks every output immediately, independent of the clock.
    if (rst == RstEnable) begin
      stallreq_from_ex = 1'b0;
      whilo_o          = 1'b0;
      mul_wdata_o      = ZeroWord;
      hi_o             = ZeroWord;
      lo_o             = ZeroWord;
    end
  end
`else
  // No accumulate path: clock, flush and forwarded HI/LO have no consumers.
  logic unused_inputs;
  assign unused_inputs = ^{clk, flush_i, hi_i, lo_i};

  always_comb begin
    stallreq_from_ex = 1'b0;
    whilo_o          = 1'b0;
    mul_wdata_o      = ZeroWord;
    hi_o             = ZeroWord;
    lo_o             = ZeroWord;

    if (rst != RstEnable) begin
      if (aluop_i == ExeMultOp || aluop_i == ExeMultuOp) begin
        {hi_o, lo_o} = product;
        whilo_o      = WriteEnable;
      end else if (aluop_i == ExeMulOp) begin
        mul_wdata_o = product[RegW-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mul_acc.sv
// Self-checking bench for ex_mul_acc: directed cases followed by random ops,
// all compared against an arithmetic reference computed here.
module tb_ex_mul_acc;
  import ex_mul_acc_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        flush_i;
  logic        stallreq_from_ex;
  logic [31:0] mul_wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;

  int n_tests;
  int n_fail;

  ex_mul_acc dut (
    .clk              (clk),
    .rst              (rst),
    .aluop_i          (aluop_i),
    .reg1_i           (reg1_i),
    .reg2_i           (reg2_i),
    .hi_i             (hi_i),
    .lo_i             (lo_i),
    .flush_i          (flush_i),
    .stallreq_from_ex (stallreq_from_ex),
    .mul_wdata_o      (mul_wdata_o),
    .hi_o             (hi_o),
    .lo_o             (lo_o),
    .whilo_o          (whilo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] exp_hilo,
                         input logic [31:0] exp_mul, input logic exp_we, input logic exp_stall);
    chk({tag, ".hilo"}, {hi_o, lo_o}, exp_hilo);
    chk({tag, ".mul"}, {32'd0, mul_wdata_o}, {32'd0, exp_mul});
    chk({tag, ".whilo"}, {63'd0, whilo_o}, {63'd0, exp_we});
    chk({tag, ".stall"}, {63'd0, stallreq_from_ex}, {63'd0, exp_stall});
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] ref_product(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (op == ExeMultOp || op == ExeMulOp || op == ExeMaddOp || op == ExeMsubOp) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic fl);
    aluop_i = op;
    reg1_i  = a;
    reg2_i  = b;
    hi_i    = h;
    lo_i    = l;
    flush_i = fl;
  endtask

  // Runs one full op starting just after a falling edge; ends after a falling edge.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
    logic [63:0] p;
    logic [63:0] acc;
    p = ref_product(op, a, b);
    drive(op, a, b, h, l, 1'b0);
    #1;
    if (op == ExeMultOp || op == ExeMultuOp) begin
      chk_out(tag, p, 32'd0, 1'b1, 1'b0);
    end else if (op == ExeMulOp) begin
      chk_out(tag, 64'd0, p[31:0], 1'b0, 1'b0);
    end else if (op == ExeMaddOp || op == ExeMadduOp || op == ExeMsubOp || op == ExeMsubuOp) begin
`ifdef EX_MUL_ACC_MADD_EN
      chk_out({tag, ".c1"}, 64'd0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      if (op == ExeMsubOp || op == ExeMsubuOp) acc = {h, l} - p;
      else acc = {h, l} + p;
      chk_out({tag, ".c2"}, acc, 32'd0, 1'b1, 1'b0);
`else
      chk_out(tag, 64'd0, 32'd0, 1'b0, 1'b0);
`endif
    end else begin
      chk_out(tag, 64'd0, 32'd0, 1'b0, 1'b0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ops [8];
    logic [7:0] op;
    n_tests = 0;
    n_fail  = 0;
    ops[0] = ExeMultOp;  ops[1] = ExeMultuOp; ops[2] = ExeMulOp;   ops[3] = ExeMaddOp;
    ops[4] = ExeMadduOp; ops[5] = ExeMsubOp;  ops[6] = ExeMsubuOp; ops[7] = 8'h21;

    // Reset holds all outputs at zero even with a live MULT on the inputs.
    rst = 1'b1;
    drive(ExeMultOp, 32'h1234_5678, 32'h9abc_def0, 32'd1, 32'd2, 1'b0);
    #1;
    chk_out("reset", 64'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic points.
    drive(ExeMultOp, 32'hFFFF_FFFE, 32'h0000_0003, 32'd0, 32'd0, 1'b0);
    #1;
    chk_out("mult_neg", 64'hFFFF_FFFF_FFFF_FFFA, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    drive(ExeMultuOp, 32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 32'd0, 1'b0);
    #1;
    chk_out("multu", 64'h0000_0001_FFFF_FFFE, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    drive(ExeMulOp, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b0);
    #1;
    chk_out("mul", 64'd0, 32'hFFFF_FFEB, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'h00, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1, 32'h2, 1'b0);
    #1;
    chk_out("other_op", 64'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);

`ifdef EX_MUL_ACC_MADD_EN
    drive(ExeMaddOp, 32'd4, 32'd6, 32'd0, 32'd5, 1'b0);
    #1;
    chk_out("madd.c1", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_out("madd.c2", 64'h0000_0000_0000_001D, 32'd0, 1'b1, 1'b0);
    @(negedge clk);

    drive(ExeMsubuOp, 32'd3, 32'd5, 32'd0, 32'd10, 1'b0);
    #1;
    chk_out("msubu.c1", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_out("msubu.c2", 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, 1'b1, 1'b0);
    @(negedge clk);

    // Flush during ACC: no write, and the next MADD starts from IDLE.
    drive(ExeMaddOp, 32'd9, 32'd9, 32'd0, 32'd1, 1'b0);
    #1;
    chk_out("flush.c1", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk_out("flush.c2", 64'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk_out("flush.idle", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_out("flush.redo", 64'd82, 32'd0, 1'b1, 1'b0);
    @(negedge clk);

    // Reset pulse in ACC: outputs drop at once and the op restarts from IDLE.
    drive(ExeMsubOp, 32'd2, 32'd3, 32'd0, 32'd100, 1'b0);
    #1;
    chk_out("rst.c1", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("rst.during", 64'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("rst.idle", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk_out("rst.redo", 64'd94, 32'd0, 1'b1, 1'b0);
    @(negedge clk);

    // Leaving ACC through a non-accumulate op: that op executes normally.
    drive(ExeMaddOp, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0);
    #1;
    chk_out("leave.c1", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    aluop_i = ExeMultuOp;
    #1;
    chk_out("leave.mult", 64'd25, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    aluop_i = ExeMaddOp;
    #1;
    chk_out("leave.idle", 64'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    aluop_i = 8'h00;
    @(negedge clk);
`endif

    // Directed accumulate ops through the reference path (also covers disabled builds).
    run_op("madd_ref", ExeMaddOp, 32'd4, 32'd6, 32'd0, 32'd5);
    run_op("msub_ref", ExeMsubOp, 32'hFFFF_FFFF, 32'd7, 32'h0, 32'h0);

    // Random ops, back-to-back.
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 7)];
      run_op($sformatf("rnd%0d_op%02h", i, op), op, $urandom, $urandom, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ex_mul_acc.md
EX_MUL_ACC -- requirements
Module: ex_mul_acc

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset (`RstEnable = 1'b1).
REQ-003 SHALL have port aluop_i  input  8 (`AluOpBus)  operation code issued by the decode stage.
REQ-004 SHALL have ports reg1_i and reg2_i  input  32 each  operands, already forwarded.
REQ-005 SHALL have ports hi_i and lo_i  input  32 each  current HI/LO, already forwarded.
REQ-006 SHALL have port flush_i  input  1  abandons any accumulate in progress.
REQ-007 SHALL have port stallreq_from_ex  output  1  pipeline stall request to ctrl.
REQ-008 SHALL have port mul_wdata_o  output  32  GPR result for MUL.
REQ-009 SHALL have ports hi_o and lo_o  output  32 each  new HI/LO.
REQ-010 SHALL have port whilo_o  output  1  HI/LO write enable.

Function
REQ-011 SHALL compute a 64-bit product: unsigned ops (MULTU, MADDU, MSUBU) use raw operands; signed ops (MULT, MUL, MADD, MSUB) negate negative operands, multiply magnitudes, and negate the product when the operand signs differ.
REQ-012 SHALL, for MULT/MULTU, drive {hi_o,lo_o} = product, whilo_o=1 and stallreq_from_ex=0 in the same cycle (zero latency).
REQ-013 SHALL, for MUL, drive mul_wdata_o = product[31:0] with whilo_o=0 in the same cycle.
REQ-014 SHALL implement a two-state FSM, IDLE and ACC, for MADD/MADDU/MSUB/MSUBU.
REQ-015 SHALL, in IDLE with an accumulate op and no flush_i:
- register hilo_temp = product (MADD/MADDU) or the two's-complement negation of the product (MSUB/MSUBU);
- assert stallreq_from_ex=1 and whilo_o=0;
- go to ACC.
REQ-016 SHALL, in ACC with the same accumulate op held by the stall:
- drive {hi_o,lo_o} = hilo_temp + {hi_i,lo_i} (mod 2^64);
- set whilo_o=1 and stallreq_from_ex=0;
- return to IDLE.
REQ-017 SHALL return from ACC to IDLE with whilo_o=0 and stallreq_from_ex=0 if aluop_i is no longer an accumulate op.
REQ-018 SHALL make flush_i=1 force the next state to IDLE and drive stallreq_from_ex=0 and whilo_o=0 in that cycle.
REQ-019 SHALL, for any other aluop_i, drive whilo_o=0, stallreq_from_ex=0, and mul_wdata_o, hi_o, lo_o = 0.
REQ-020 SHALL start back-to-back accumulate ops with a fresh IDLE->ACC sequence; each op costs exactly 2 cycles.

Reset
REQ-021 SHALL, while rst=1 (asynchronously), force state=IDLE, hilo_temp=0, and every output to 0.
REQ-022 SHALL discard a partial accumulate when rst asserts mid-ACC, and SHALL NOT write HI/LO for it.

Configuration
REQ-023 SHALL, with macro EX_MUL_ACC_MADD_EN defined, implement REQ-014..REQ-018 and REQ-020.
REQ-024 SHALL, without EX_MUL_ACC_MADD_EN, treat MADD/MADDU/MSUB/MSUBU as REQ-019 ops, omit the FSM and hilo_temp, and tie stallreq_from_ex to 0.

Structure
REQ-025 SHALL take all opcode constants (`EXE_*_OP), `AluOpBus, `RegBus, `ZeroWord, `RstEnable and `WriteEnable from the shared defines file; the FSM state encodings SHALL also be added there.
REQ-026 SHALL instantiate one sub-module, mul32x32u, a pure combinational 32x32->64 unsigned multiplier; sign handling stays in ex_mul_acc.

Verification
REQ-027 SHALL check MULT, reg1=0xFFFFFFFE, reg2=0x00000003 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, whilo_o=1, stallreq_from_ex=0 in the same cycle.
REQ-028 SHALL check MULTU, reg1=0xFFFFFFFF, reg2=0x00000002 -> hi_o=0x00000001, lo_o=0xFFFFFFFE.
REQ-029 SHALL check MUL, reg1=7, reg2=0xFFFFFFFD -> mul_wdata_o=0xFFFFFFEB, whilo_o=0.
REQ-030 SHALL check MADD held two cycles, hi_i=0, lo_i=5, reg1=4, reg2=6:
- cycle 1: stallreq_from_ex=1, whilo_o=0;
- cycle 2: hi_o=0, lo_o=0x1D, whilo_o=1, stallreq_from_ex=0.
REQ-031 SHALL check MSUBU, hi_i=0, lo_i=10, reg1=3, reg2=5 -> cycle 2: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFB.
REQ-032 SHALL check abort paths:
- MADD cycle 1 then flush_i=1 -> stallreq_from_ex=0 and whilo_o=0 in that cycle, IDLE next;
- rst pulse during ACC -> all outputs 0 immediately, no HI/LO write.
